// File: rtl/mux_display_counter.sv
// Multiplexed seven-segment BCD counter: prescaled up/down/loadable N-digit count,
// scanned MSD-to-LSD onto a common-segment display with polarity and zero blanking.
module mux_display_counter #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 4096,
    parameter int unsigned COUNT_DIV      = 1048576,
    parameter bit          ACTIVE_LOW_SEL = 1'b1,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    en_in,
    input  logic                    up_in,
    input  logic                    load_in,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count_out,
    output logic                    wrap_out,
    output logic [NUM_DIGITS-1:0]   digit_select,
    output logic [7:0]              led_segments
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PreLast  = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] ScanLast = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] SelOff = ACTIVE_LOW_SEL ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [7:0]            SegOff = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    logic [PW-1:0]           pre_q, pre_d;
    logic [4*NUM_DIGITS-1:0] count_q, count_d, stepped;
    logic                    wrap_q, wrap_d;
    logic [SW-1:0]           scan_timer_q, scan_timer_d;
    logic [IW-1:0]           scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]   digit_select_q, digit_select_d;
    logic [7:0]              led_segments_q, led_segments_d;

    logic                    step;
    logic                    carry;
    logic [3:0]              nib;

    // Count path: prescaler, single-cycle BCD ripple step, load with clamp.
    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        step    = 1'b0;
        stepped = count_q;
        carry   = 1'b1;
        nib     = 4'd0;

        if (en_in) begin
            if (pre_q == PreLast) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        // carry doubles as borrow; it survives the loop only on roll-over/under
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            nib = count_q[4*i +: 4];
            if (carry) begin
                if (up_in) begin
                    if (nib == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = nib + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end

        if (load_in) begin
            pre_d = '0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                count_d[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
            end
        end else if (step) begin
            count_d = stepped;
            wrap_d  = carry;
        end
    end

    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;
    logic                  blank;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [3:0]            cur_digit;
    logic [7:0]            pattern;

    // Scan path: outputs are registered from the current index and count together,
    // so the segment pattern always belongs to the digit being selected.
    always_comb begin
        scan_timer_d = scan_timer_q + 1'b1;
        scan_idx_d   = scan_idx_q;
        if (scan_timer_q == ScanLast) begin
            scan_timer_d = '0;
            scan_idx_d   = (scan_idx_q == '0) ? IdxLast : scan_idx_q - 1'b1;
        end

        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run     = zero_run & (count_q[4*k +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end

        cur_digit  = count_q[4*scan_idx_q +: 4];
        blank      = BLANK_LEADING && (scan_idx_q != '0) && lead_zero[scan_idx_q];
        pattern    = blank ? 8'h00 : {1'b0, seg7(cur_digit)};
        sel_onehot = '0;
        sel_onehot[scan_idx_q] = 1'b1;

        digit_select_d = ACTIVE_LOW_SEL ? ~sel_onehot : sel_onehot;
        led_segments_d = ACTIVE_LOW_SEG ? ~pattern : pattern;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pre_q          <= '0;
            count_q        <= '0;
            wrap_q         <= 1'b0;
            scan_timer_q   <= '0;
            scan_idx_q     <= IdxLast;
            digit_select_q <= SelOff;
            led_segments_q <= SegOff;
        end else begin
            pre_q          <= pre_d;
            count_q        <= count_d;
            wrap_q         <= wrap_d;
            scan_timer_q   <= scan_timer_d;
            scan_idx_q     <= scan_idx_d;
            digit_select_q <= digit_select_d;
            led_segments_q <= led_segments_d;
        end
    end

    assign count_out    = count_q;
    assign wrap_out     = wrap_q;
    assign digit_select = digit_select_q;
    assign led_segments = led_segments_q;

endmodule

// File: tb/tb_mux_display_counter.sv
// Directed bench for mux_display_counter: one active-low/blanking instance and one
// active-high/no-blanking instance share the same clock and stimulus.
module tb_mux_display_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] lv;

    logic [15:0] count_a, count_p;
    logic        wrap_a, wrap_p;
    logic [3:0]  sel_a, sel_p;
    logic [7:0]  seg_a, seg_p;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [3:0] sel_lo [4];
    logic [3:0] sel_hi [4];

    always #5 clk = ~clk;

    mux_display_counter #(
        .NUM_DIGITS(4), .SCAN_DIV(2), .COUNT_DIV(2),
        .ACTIVE_LOW_SEL(1'b1), .ACTIVE_LOW_SEG(1'b1), .BLANK_LEADING(1'b1)
    ) dut (
        .clk_in(clk), .rst_in(rst), .en_in(en), .up_in(up), .load_in(load),
        .load_value(lv), .count_out(count_a), .wrap_out(wrap_a),
        .digit_select(sel_a), .led_segments(seg_a)
    );

    mux_display_counter #(
        .NUM_DIGITS(4), .SCAN_DIV(2), .COUNT_DIV(2),
        .ACTIVE_LOW_SEL(1'b0), .ACTIVE_LOW_SEG(1'b0), .BLANK_LEADING(1'b0)
    ) dut_p (
        .clk_in(clk), .rst_in(rst), .en_in(en), .up_in(up), .load_in(load),
        .load_value(lv), .count_out(count_p), .wrap_out(wrap_p),
        .digit_select(sel_p), .led_segments(seg_p)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sel_lo = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        sel_hi = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 16'h0000;

        // Reset
        tick(3);
        check("rst_count", 32'(count_a), 32'h0000);
        check("rst_wrap", 32'(wrap_a), 32'h0);
        check("rst_sel", 32'(sel_a), 32'hF);
        check("rst_seg", 32'(seg_a), 32'hFF);
        rst = 1'b0;
        tick(1);
        check("first_sel", 32'(sel_a), 32'h7);
        check("first_seg", 32'(seg_a), 32'hFF);

        // Up with carry, then roll-over
        load = 1'b1; lv = 16'h0199; en = 1'b1; up = 1'b1;
        tick(1);
        load = 1'b0;
        check("load_0199", 32'(count_a), 32'h0199);
        tick(2);
        check("up_carry", 32'(count_a), 32'h0200);
        check("up_carry_wrap", 32'(wrap_a), 32'h0);
        load = 1'b1; lv = 16'h9999;
        tick(1);
        load = 1'b0;
        tick(1);
        check("pre_roll_wrap", 32'(wrap_a), 32'h0);
        tick(1);
        check("roll_count", 32'(count_a), 32'h0000);
        check("roll_wrap", 32'(wrap_a), 32'h1);
        tick(1);
        check("roll_wrap_end", 32'(wrap_a), 32'h0);
        check("roll_hold", 32'(count_a), 32'h0000);

        // Down with roll-under, then load over a coincident step
        up = 1'b0; load = 1'b1; lv = 16'h0000;
        tick(1);
        load = 1'b0;
        tick(2);
        check("under_count", 32'(count_a), 32'h9999);
        check("under_wrap", 32'(wrap_a), 32'h1);
        tick(1);
        check("under_wrap_end", 32'(wrap_a), 32'h0);
        load = 1'b1; lv = 16'h0042;
        tick(1);
        load = 1'b0;
        check("load_prio_count", 32'(count_a), 32'h0042);
        check("load_prio_wrap", 32'(wrap_a), 32'h0);

        // Clamp, then enable gating holds the prescaler
        load = 1'b1; lv = 16'h0A5F;
        tick(1);
        load = 1'b0; en = 1'b0;
        check("clamp", 32'(count_a), 32'h0959);
        tick(9);
        check("en_hold", 32'(count_a), 32'h0959);
        en = 1'b1;
        tick(1);
        check("pre_held", 32'(count_a), 32'h0959);
        tick(1);
        check("down_step", 32'(count_a), 32'h0958);

        // Scan order and leading-zero blanking
        en = 1'b0; rst = 1'b1;
        tick(1);
        rst = 1'b0; load = 1'b1; lv = 16'h0007;
        tick(1);
        load = 1'b0;
        check("load_0007", 32'(count_a), 32'h0007);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1);
            check($sformatf("scan7_sel%0d", i), 32'(sel_a), 32'(sel_lo[i/2]));
            check($sformatf("scan7_seg%0d", i), 32'(seg_a), (i / 2 == 3) ? 32'hF8 : 32'hFF);
        end
        load = 1'b1; lv = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            load = 1'b0;
            check($sformatf("scan0_sel%0d", i), 32'(sel_a), 32'(sel_lo[i/2]));
            check($sformatf("scan0_seg%0d", i), 32'(seg_a), (i / 2 == 3) ? 32'hC0 : 32'hFF);
        end

        // Active-high polarity, no blanking
        rst = 1'b1;
        tick(1);
        check("p_rst_count", 32'(count_p), 32'h0000);
        check("p_rst_wrap", 32'(wrap_p), 32'h0);
        check("p_rst_sel", 32'(sel_p), 32'h0);
        check("p_rst_seg", 32'(seg_p), 32'h00);
        rst = 1'b0; load = 1'b1; lv = 16'h0008;
        tick(1);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1);
            check($sformatf("pol_sel%0d", i), 32'(sel_p), 32'(sel_hi[i/2]));
            check($sformatf("pol_seg%0d", i), 32'(seg_p), (i / 2 == 3) ? 32'h7F : 32'h3F);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
